// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing / test-pattern generator.
package vga_pkg;

  // Default 640x480@60 timing.
  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;
  localparam int unsigned DefCw      = 4;

  // Runtime-selectable test patterns.
  typedef enum logic [2:0] {
    ModeBlack    = 3'd0,
    ModeSolid    = 3'd1,
    ModeBars     = 3'd2,
    ModeCheck    = 3'd3,
    ModeGrad     = 3'd4,
    ModeMovBar   = 3'd5,
    ModeGrid     = 3'd6,
    ModeInvCheck = 3'd7
  } mode_e;

  // Colour of the default 12-bit pin group.
  typedef struct packed {
    logic [DefCw-1:0] r;
    logic [DefCw-1:0] g;
    logic [DefCw-1:0] b;
  } color_t;

endpackage

// File: rtl/vga_pattern_rom_logic.sv
// Combinational test-pattern colour for one pixel position.
module vga_pattern_rom_logic
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned HW       = 10,
  parameter int unsigned VW       = 10,
  parameter int unsigned CW       = 4,
  parameter int unsigned FCW      = 8
) (
  input  logic [HW-1:0]   x_i,
  input  logic [VW-1:0]   y_i,
  input  mode_e           mode_i,
  input  logic [3*CW-1:0] fg_color_i,
  input  logic [FCW-1:0]  frame_cnt_i,
  output logic [3*CW-1:0] color_o
);

  // Bar index x*8/H_ACTIVE as (x*BarMul)>>BarShift; exact for x < H_ACTIVE
  // because H_ACTIVE^2 <= 2^BarShift.
  localparam int unsigned     BarShift = 2 * $clog2(H_ACTIVE);
  localparam longint unsigned BarMul   = ((64'd8 << BarShift) + H_ACTIVE - 1) / H_ACTIVE;
  localparam logic [CW-1:0]   Max      = '1;

  logic [5:0]    x_lo;
  logic [5:0]    y_lo;
  logic [2:0]    bar_idx;
  logic          chk;
  logic          on_grid;
  logic [31:0]   x_div;
  logic [CW-1:0] grad;
  logic [31:0]   mov_off;
  logic          in_mov;
  logic          unused_y_hi;

  // Only the low six bits of y feed the cell/grid patterns.
  assign unused_y_hi = ^y_i;

  // Per-pattern terms, then the mode select.
  always_comb begin
    x_lo    = 6'(x_i);
    y_lo    = 6'(y_i);
    bar_idx = 3'((64'(x_i) * BarMul) >> BarShift);
    chk     = x_lo[5] ^ y_lo[5];
    on_grid = (x_lo[4:0] == 5'd0) || (y_lo[4:0] == 5'd0);
    x_div   = 32'(x_i) >> 6;
    grad    = (x_div > 32'(Max)) ? Max : CW'(x_div);
    mov_off = 32'({frame_cnt_i, 2'b00}) % H_ACTIVE;
    // Bar does not wrap past the right edge of the active area.
    in_mov  = (32'(x_i) >= mov_off) && (32'(x_i) < mov_off + 32'd16);
    color_o = '0;
    unique case (mode_i)
      ModeBlack:    color_o = '0;
      ModeSolid:    color_o = fg_color_i;
      ModeBars:     color_o = {{CW{bar_idx[2]}}, {CW{bar_idx[1]}}, {CW{bar_idx[0]}}};
      ModeCheck:    color_o = {(3 * CW){chk}};
      ModeGrad:     color_o = {grad, grad, grad};
      ModeMovBar:   color_o = {(3 * CW){in_mov}};
      ModeGrid:     color_o = on_grid ? fg_color_i : '0;
      ModeInvCheck: color_o = {(3 * CW){~chk}};
    endcase
  end

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA timing generator with registered test-pattern output.
module vga_timing_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = DefCw,
  parameter int unsigned FCW      = 8,
  localparam int unsigned HW      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int unsigned VW      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pix_en,
  input  logic [2:0]      mode,
  input  logic [3*CW-1:0] fg_color,
  output logic [CW-1:0]   r,
  output logic [CW-1:0]   g,
  output logic [CW-1:0]   b,
  output logic            hs,
  output logic            vs,
  output logic            de,
  output logic [HW-1:0]   hpos,
  output logic [VW-1:0]   vpos,
  output logic            frame_start,
  output logic [FCW-1:0]  frame_cnt
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] HLast   = HW'(HTotal - 1);
  localparam logic [HW-1:0] HActive = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HsStart = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HsEnd   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VLast   = VW'(VTotal - 1);
  localparam logic [VW-1:0] VActive = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VsStart = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VsEnd   = VW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : gen_param_check
    $error("vga_timing_pattern_gen: active, porch and sync sizes must all be >= 1");
  end

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
  } pix_color_t;

  logic [HW-1:0]   hpos_q, hpos_d;
  logic [VW-1:0]   vpos_q, vpos_d;
  logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;
  mode_e           mode_q, mode_d;
  pix_color_t      color_q, color_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            de_q, de_d;
  logic            frame_start_q, frame_start_d;
  logic [3*CW-1:0] pat_color;
  logic            line_end;
  logic            frame_end;

  vga_pattern_rom_logic #(
    .H_ACTIVE (H_ACTIVE),
    .HW       (HW),
    .VW       (VW),
    .CW       (CW),
    .FCW      (FCW)
  ) u_pattern (
    .x_i         (hpos_q),
    .y_i         (vpos_q),
    .mode_i      (mode_q),
    .fg_color_i  (fg_color),
    .frame_cnt_i (frame_cnt_q),
    .color_o     (pat_color)
  );

  // Counter advance and pixel stage, all computed from the pre-increment position.
  always_comb begin
    line_end      = (hpos_q == HLast);
    frame_end     = line_end && (vpos_q == VLast);
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    frame_cnt_d   = frame_cnt_q;
    mode_d        = mode_q;
    color_d       = color_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    de_d          = de_q;
    frame_start_d = pix_en && frame_end;
    if (pix_en) begin
      hpos_d = line_end ? '0 : hpos_q + HW'(1);
      if (line_end) begin
        vpos_d = (vpos_q == VLast) ? '0 : vpos_q + VW'(1);
      end
      if (frame_end) begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
        mode_d      = mode_e'(mode);
      end
      de_d    = (hpos_q < HActive) && (vpos_q < VActive);
      hs_d    = ((hpos_q >= HsStart) && (hpos_q < HsEnd)) ? HS_POL : ~HS_POL;
      vs_d    = ((vpos_q >= VsStart) && (vpos_q < VsEnd)) ? VS_POL : ~VS_POL;
      color_d = de_d ? pix_color_t'(pat_color) : '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q        <= '0;
      vpos_q        <= '0;
      frame_cnt_q   <= '0;
      mode_q        <= ModeBlack;
      color_q       <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_cnt_q   <= frame_cnt_d;
      mode_q        <= mode_d;
      color_q       <= color_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign r           = color_q.r;
  assign g           = color_q.g;
  assign b           = color_q.b;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench: three configurations of the generator against a tick-indexed reference model.
module tb_vga_timing_pattern_gen;

  localparam int MFrame  = 112 * 46;  // pix_en ticks per frame of the mid-size instance
  localparam int MaxFail = 50;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, hpol, vpol, fcw;
  } cfg_t;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] h;
    logic [15:0] v;
    logic        fs;
    logic [7:0]  fc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        pix_en;
  logic [2:0]  mode;
  logic [11:0] fg_color;

  logic [3:0] d_r, d_g, d_b, m_r, m_g, m_b, s_r, s_g, s_b;
  logic       d_hs, d_vs, d_de, d_fs, m_hs, m_vs, m_de, m_fs, s_hs, s_vs, s_de, s_fs;
  logic [9:0] d_hpos, d_vpos;
  logic [6:0] m_hpos;
  logic [5:0] m_vpos;
  logic [3:0] s_hpos;
  logic [2:0] s_vpos;
  logic [7:0] d_fc, s_fc;
  logic [2:0] m_fc;

  cfg_t   cfg [3];
  exp_t   ex [3];
  int     lmode [3];
  longint tick;
  int     n_tests;
  int     n_fail;
  int     seq [8] = '{2, 3, 4, 5, 6, 7, 1, 0};

  vga_timing_pattern_gen u_def (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode), .fg_color(fg_color),
    .r(d_r), .g(d_g), .b(d_b), .hs(d_hs), .vs(d_vs), .de(d_de),
    .hpos(d_hpos), .vpos(d_vpos), .frame_start(d_fs), .frame_cnt(d_fc)
  );

  vga_timing_pattern_gen #(
    .H_ACTIVE(96), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b1), .CW(4), .FCW(3)
  ) u_mid (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode), .fg_color(fg_color),
    .r(m_r), .g(m_g), .b(m_b), .hs(m_hs), .vs(m_vs), .de(m_de),
    .hpos(m_hpos), .vpos(m_vpos), .frame_start(m_fs), .frame_cnt(m_fc)
  );

  vga_timing_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(4), .FCW(8)
  ) u_sml (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode), .fg_color(fg_color),
    .r(s_r), .g(s_g), .b(s_b), .hs(s_hs), .vs(s_vs), .de(s_de),
    .hpos(s_hpos), .vpos(s_vpos), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern colour straight from the pattern definitions (M = 15).
  function automatic logic [11:0] colour(input cfg_t c, input int x, input int y, input int m,
                                         input int fc, input logic [11:0] fg);
    int i, gv, off;
    bit chk;
    chk = (((x / 32) + (y / 32)) % 2) == 1;
    case (m)
      1: return fg;
      2: begin
        i = x * 8 / c.ha;
        return {(i[2] ? 4'hF : 4'h0), (i[1] ? 4'hF : 4'h0), (i[0] ? 4'hF : 4'h0)};
      end
      3: return chk ? 12'hFFF : 12'h000;
      4: begin
        gv = (x / 64 > 15) ? 15 : x / 64;
        return {gv[3:0], gv[3:0], gv[3:0]};
      end
      5: begin
        off = (fc * 4) % c.ha;
        return (x >= off && x < off + 16) ? 12'hFFF : 12'h000;
      end
      6: return (x % 32 == 0 || y % 32 == 0) ? fg : 12'h000;
      7: return chk ? 12'h000 : 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  // Outputs expected just after pix_en tick number t (0-based since reset release).
  function automatic exp_t model(input cfg_t c, input longint t, input int lm,
                                 input logic [11:0] fg);
    exp_t e;
    int ht, vt, x, y, f, fmod;
    ht   = c.ha + c.hfp + c.hsw + c.hbp;
    vt   = c.va + c.vfp + c.vsw + c.vbp;
    fmod = 1 << c.fcw;
    x    = int'(t % ht);
    y    = int'((t / ht) % vt);
    f    = int'(t / (ht * vt));
    e.de = (x < c.ha) && (y < c.va);
    e.hs = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hsw) ? (c.hpol != 0) : (c.hpol == 0);
    e.vs = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vsw) ? (c.vpol != 0) : (c.vpol == 0);
    e.rgb = e.de ? colour(c, x, y, lm, f % fmod, fg) : 12'h000;
    e.h  = 16'((t + 1) % ht);
    e.v  = 16'(((t + 1) / ht) % vt);
    e.fs = (x == ht - 1) && (y == vt - 1);
    e.fc = 8'(((t + 1) / (ht * vt)) % fmod);
    return e;
  endfunction

  function automatic exp_t reset_exp(input cfg_t c);
    exp_t e;
    e     = '0;
    e.hs  = (c.hpol == 0);
    e.vs  = (c.vpol == 0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    assert (act === want) else begin
      n_fail++;
      $error("FAIL %s tick=%0d: observed %h expected %h", tag, tick, act, want);
    end
  endtask

  task automatic check_all();
    check("def.pix", 64'({d_r, d_g, d_b, d_hs, d_vs, d_de}),
          64'({ex[0].rgb, ex[0].hs, ex[0].vs, ex[0].de}));
    check("def.pos", 64'({d_fc, 16'(d_hpos), 16'(d_vpos), d_fs}),
          64'({ex[0].fc, ex[0].h, ex[0].v, ex[0].fs}));
    check("mid.pix", 64'({m_r, m_g, m_b, m_hs, m_vs, m_de}),
          64'({ex[1].rgb, ex[1].hs, ex[1].vs, ex[1].de}));
    check("mid.pos", 64'({8'(m_fc), 16'(m_hpos), 16'(m_vpos), m_fs}),
          64'({ex[1].fc, ex[1].h, ex[1].v, ex[1].fs}));
    check("sml.pix", 64'({s_r, s_g, s_b, s_hs, s_vs, s_de}),
          64'({ex[2].rgb, ex[2].hs, ex[2].vs, ex[2].de}));
    check("sml.pos", 64'({s_fc, 16'(s_hpos), 16'(s_vpos), s_fs}),
          64'({ex[2].fc, ex[2].h, ex[2].v, ex[2].fs}));
  endtask

  // Mode is pinned to a known sequence late in each mid-size frame, random otherwise.
  task automatic drive_inputs();
    if (int'(tick % MFrame) >= 3000) mode = 3'(seq[int'(tick / MFrame) % 8]);
    else if ($urandom_range(0, 49) == 0) mode = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 99) == 0) fg_color = 12'($urandom);
  endtask

  // One clock; a pix_en tick advances the model, otherwise everything must hold.
  task automatic step(input bit en);
    pix_en = en;
    for (int k = 0; k < 3; k++) begin
      if (en) begin
        ex[k] = model(cfg[k], tick, lmode[k], fg_color);
        if (ex[k].fs) lmode[k] = int'(mode);
      end else begin
        ex[k].fs = 1'b0;
      end
    end
    if (en) tick++;
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    tick     = 0;
    rst_n    = 1'b0;
    pix_en   = 1'b0;
    mode     = 3'd0;
    fg_color = 12'h000;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 8};
    cfg[1] = '{96, 4, 8, 4, 40, 2, 2, 2, 0, 1, 3};
    cfg[2] = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 0, 8};
    for (int k = 0; k < 3; k++) begin
      ex[k]    = reset_exp(cfg[k]);
      lmode[k] = 0;
    end

    // Reset held with pix_en and inputs toggling.
    for (int i = 0; i < 12; i++) begin
      pix_en   = 1'($urandom);
      mode     = 3'($urandom);
      fg_color = 12'($urandom);
      @(posedge clk);
      #1;
      check_all();
    end
    rst_n = 1'b1;

    // Full-rate pixel clock.
    for (int i = 0; i < 31000 && n_fail < MaxFail; i++) begin
      drive_inputs();
      step(1'b1);
    end
    // pix_en every second clock.
    for (int i = 0; i < 16000 && n_fail < MaxFail; i++) begin
      drive_inputs();
      step(i % 2 == 0);
    end
    // Irregular pix_en.
    for (int i = 0; i < 8000 && n_fail < MaxFail; i++) begin
      drive_inputs();
      step($urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
